pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_busy_timer.sv | 28 ++
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared widths, stall masks, state encodings and timeout limit for pipe_ctrl
package pipe_ctrl_pkg;

  localparam int STALL_W    = 6;
  localparam int PC_W       = 32;
  localparam int BUSY_CNT_W = 6;

  // Saturating limit of the EX busy counter; reaching it raises busy_timeout.
  localparam logic [BUSY_CNT_W-1:0] BUSY_LIMIT = 6'd63;

  // Hold vector bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_EXBUSY = 2'd1,
    ST_FLUSH  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard request / pipeline control bundle between the pipeline and pipe_ctrl
// Requests : stallreq_id, stallreq_ex, ex_done, excp_req, excp_vec[31:0]
// Controls : stall[5:0], bubble_ex, flush, new_pc[31:0], busy_timeout
// master = pipeline side (raises requests), slave = pipe_ctrl (answers with controls)
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic               stallreq_id;
  logic               stallreq_ex;
  logic               ex_done;
  logic               excp_req;
  logic [PC_W-1:0]    excp_vec;
  logic [STALL_W-1:0] stall;
  logic               bubble_ex;
  logic               flush;
  logic [PC_W-1:0]    new_pc;
  logic               busy_timeout;

  modport master (
    output stallreq_id, stallreq_ex, ex_done, excp_req, excp_vec,
    input  stall, bubble_ex, flush, new_pc, busy_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, ex_done, excp_req, excp_vec,
    output stall, bubble_ex, flush, new_pc, busy_timeout
  );

endinterface

// File: rtl/pipe_busy_timer.sv
// rtl/pipe_busy_timer.sv - cycle counter for time spent waiting on a multi-cycle EX operation
// clk, rst : clock, synchronous active-high reset
// clear    : force count to zero (held while not busy, so it restarts on each entry)
// enable   : advance count by one this cycle
// count    : cycles counted since the last clear
// expired  : count has reached BUSY_LIMIT
module pipe_busy_timer
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  output logic [BUSY_CNT_W-1:0] count,
  output logic                  expired
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == BUSY_LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard / exception controller (RUN, EXBUSY, FLUSH)
// clk, rst : clock, synchronous active-high reset
// pif      : pipe_ctrl_if.slave; requests in, stall/bubble_ex/flush/new_pc/busy_timeout out
// stall, bubble_ex and flush are combinational from the current state and inputs;
// new_pc and busy_timeout are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  pif
);

  pipe_state_e           state_q;
  pipe_state_e           state_d;
  logic [STALL_W-1:0]    stall_c;
  logic                  bubble_c;
  logic                  flush_c;
  logic [PC_W-1:0]       new_pc_q;
  logic                  timeout_q;
  logic [BUSY_CNT_W-1:0] busy_cnt;
  logic                  busy_expired;
  logic                  in_exbusy;

  assign in_exbusy = (state_q == ST_EXBUSY);

  // Clearing whenever we are not busy means the count starts from zero on every
  // entry; enable stops at the limit so the counter saturates instead of wrapping.
  pipe_busy_timer u_busy_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_exbusy),
    .enable  (in_exbusy && (busy_cnt != BUSY_LIMIT)),
    .count   (busy_cnt),
    .expired (busy_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = STALL_NONE;
    bubble_c = 1'b0;
    flush_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        // EX start outranks the load-use hazard; ex_done is meaningless here.
        if (pif.stallreq_ex) begin
          stall_c = STALL_EX;
          state_d = ST_EXBUSY;
        end else if (pif.stallreq_id) begin
          stall_c  = STALL_ID;
          bubble_c = 1'b1;
        end
      end
      ST_EXBUSY: begin
        if (pif.ex_done) begin
          state_d = ST_RUN;
        end else begin
          stall_c = STALL_EX;
        end
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // An exception only changes where we go next; this cycle keeps the
    // outputs of the state being left.
    if (pif.excp_req) begin
      state_d = ST_FLUSH;
    end

    // Reset aborts everything, including a pending flush pulse.
    if (rst) begin
      state_d  = ST_RUN;
      stall_c  = STALL_NONE;
      bubble_c = 1'b0;
      flush_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      new_pc_q <= '0;
    end else if (pif.excp_req) begin
      new_pc_q <= pif.excp_vec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (in_exbusy && busy_expired && !pif.ex_done) begin
      timeout_q <= 1'b1;
    end
  end

  assign pif.stall        = stall_c;
  assign pif.bubble_ex    = bubble_c;
  assign pif.flush        = flush_c;
  assign pif.new_pc       = new_pc_q;
  assign pif.busy_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed per-cycle vectors
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  typedef struct {
    int         step;
    logic [5:0] stall;
    logic       bub;
    logic       fl;
    logic [31:0] pc;
    logic       to;
    logic       chk_regs;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic cmp(input string name, input int stp, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, stp, act, exp_v);
    end
  endtask

  // Monitor: outputs are continuous, so one expected record is consumed per cycle
  // at the falling edge, well after the inputs for that cycle settled.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      cmp("stall", e.step, {26'd0, pif.stall}, {26'd0, e.stall});
      cmp("bubble_ex", e.step, {31'd0, pif.bubble_ex}, {31'd0, e.bub});
      cmp("flush", e.step, {31'd0, pif.flush}, {31'd0, e.fl});
      if (e.chk_regs) begin
        cmp("new_pc", e.step, pif.new_pc, e.pc);
        cmp("busy_timeout", e.step, {31'd0, pif.busy_timeout}, {31'd0, e.to});
      end
    end
  end

  // One cycle of stimulus plus its expected response.
  task automatic cyc(input logic r, input logic id, input logic ex, input logic done,
                     input logic excp, input logic [31:0] vec,
                     input logic [5:0] e_stall, input logic e_bub, input logic e_fl,
                     input logic [31:0] e_pc, input logic e_to, input logic e_regs);
    exp_t e;
    #1;
    rst             = r;
    pif.stallreq_id = id;
    pif.stallreq_ex = ex;
    pif.ex_done     = done;
    pif.excp_req    = excp;
    pif.excp_vec    = vec;
    step_no++;
    e.step = step_no; e.stall = e_stall; e.bub = e_bub; e.fl = e_fl;
    e.pc = e_pc; e.to = e_to; e.chk_regs = e_regs;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pif.stallreq_id = 1'b0; pif.stallreq_ex = 1'b0; pif.ex_done = 1'b0;
    pif.excp_req = 1'b0; pif.excp_vec = '0;
    repeat (2) @(posedge clk);

    //  r  id ex dn xc vec          stall      bub fl pc           to regs
    cyc(1, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1); // reset state
    // load-use hazard for one cycle
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
    cyc(0, 1, 0, 0, 0, 32'h0,       6'b000111, 1, 0, 32'h0,       0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
    // EX op: request + 5 busy cycles stalled, done on the 6th busy cycle
    cyc(0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 1);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 0, 0, 32'h0,     6'b001111, 0, 0, 32'h0,       0, 1);
    cyc(0, 0, 0, 1, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
    // back in RUN: id hazard honoured, stray ex_done ignored
    cyc(0, 1, 0, 1, 0, 32'h0,       6'b000111, 1, 0, 32'h0,       0, 1);
    // exception during EXBUSY
    cyc(0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 1);
    cyc(0, 1, 0, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 1);
    cyc(0, 0, 0, 0, 1, 32'h20,      6'b001111, 0, 0, 32'h0,       0, 1);
    cyc(0, 0, 1, 0, 0, 32'h0,       6'b000000, 0, 1, 32'h20,      0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h20,      0, 1);
    // back-to-back exceptions: FLUSH held, new_pc re-latched
    cyc(0, 0, 0, 0, 1, 32'h100,     6'b000000, 0, 0, 32'h20,      0, 1);
    cyc(0, 0, 0, 0, 1, 32'h200,     6'b000000, 0, 1, 32'h100,     0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 1, 32'h200,     0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h200,     0, 1);
    // all requests together: exception wins, no EXBUSY afterwards
    cyc(0, 1, 1, 0, 1, 32'h40,      6'b001111, 0, 0, 32'h200,     0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 1, 32'h40,      0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h40,      0, 1);
    // reset in the third EXBUSY cycle
    cyc(0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h40,      0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h40,      0, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h40,      0, 1);
    cyc(1, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
    // reset during FLUSH: no flush pulse afterwards
    cyc(0, 0, 0, 0, 1, 32'h80,      6'b000000, 0, 0, 32'h0,       0, 1);
    cyc(1, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);
    // timeout: counter reads 63 in busy cycle 64, flag visible from cycle 65
    cyc(0, 0, 1, 0, 0, 32'h0,       6'b001111, 0, 0, 32'h0,       0, 1);
    for (int n = 1; n <= 64; n++)
      cyc(0, 0, 1, 0, 0, 32'h0,     6'b001111, 0, 0, 32'h0,       0, 1);
    for (int n = 65; n <= 66; n++)
      cyc(0, 0, 1, 0, 0, 32'h0,     6'b001111, 0, 0, 32'h0,       1, 1);
    cyc(0, 0, 0, 1, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       1, 1);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       1, 1);
    cyc(1, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 0);
    cyc(0, 0, 0, 0, 0, 32'h0,       6'b000000, 0, 0, 32'h0,       0, 1);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
